cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port between the I-cache and the D-cache of the RV32I pipeline.
- Sits below both caches and above the cacheline adaptor/main memory.
- Grants one line transaction at a time: D-priority normally, round-robin on simultaneous requests, registered handshakes, and a service watchdog.
- The pipeline buffers stay stalled while their cache waits for its `*_resp` pulse.

Parameters:
- ADDR_W, 32, line address width
- LINE_W, 256, cacheline data width
- TIMEOUT, 0, max cycles in a SERVE state before forced abort; 0 disables the watchdog

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_read  in  1  I-cache line read request (level, held until i_resp)
- i_addr  in  ADDR_W  I-cache line address
- i_resp  out  1  one-cycle pulse: I read complete
- i_rdata  out  LINE_W  line returned to I-cache, valid while i_resp=1
- d_read  in  1  D-cache line read request (level)
- d_write  in  1  D-cache line write-back request (level)
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write-back line
- d_resp  out  1  one-cycle pulse: D transaction complete
- d_rdata  out  LINE_W  line returned to D-cache, valid while d_resp=1
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  memory line address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory completion pulse
- arb_err  out  1  sticky watchdog-timeout flag

Behaviour:
- Reset (async, any state): state=IDLE, last_grant=I (so D wins the first tie), all outputs 0, arb_err=0, counter=0.
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
- IDLE:
  - Sample requests. Only d pending -> SERVE_D. Only i pending -> SERVE_I.
  - Both pending -> grant the one not equal to last_grant; update last_grant.
  - No request -> stay in IDLE.
- On the grant edge, latch address, op and wdata into internal registers. pmem_* are driven only from these registers.
  - pmem_read/pmem_write assert the cycle after grant, never combinationally from requester inputs.
- D op encoding: d_write dominates if d_read and d_write are both high (illegal); the transaction is a write.
- SERVE_x:
  - Hold pmem strobes, address and wdata stable until pmem_resp=1.
  - On pmem_resp: latch pmem_rdata into the x_rdata register; deassert strobes next cycle; go to RESP_x.
- RESP_x: x_resp=1 for exactly this one cycle, with x_rdata valid. Next state IDLE, unconditionally.
  - Consequence: at least one idle cycle between transactions; the requester has dropped its request by then.
- Latency: request seen at edge N -> pmem strobe at N+1 -> pmem_resp at edge M -> x_resp high during cycle M+1.
- Requester deasserts mid-service: the transaction is still completed and the resp pulse is still issued. No abort.
- Requester inputs change mid-service: ignored. Latched values are used.
- x_rdata holds its last value after the resp pulse; it is only meaningful while resp=1.
- The non-granted requester sees resp=0 and waits; it is granted on the next IDLE evaluation.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to SERVE_x and increments each SERVE cycle.
  - Counter reaching TIMEOUT with no pmem_resp: set arb_err (sticky until rst), drop strobes, go to RESP_x with x_rdata=0.
  - pmem_resp arriving in the same cycle as the timeout: the response wins and arb_err is not set.
- pmem_resp in IDLE/RESP states: ignored.

Test Plan:
- Reset mid-SERVE_D (pmem_write=1) -> all outputs 0 immediately (async), state IDLE; next d_read from 0x100 is granted normally with last_grant=I.
- i_read only, addr 0x0000_0040, pmem_resp after 5 cycles with rdata=0xA5..A5 -> pmem_read rises 1 cycle after request; i_resp single pulse with i_rdata=0xA5..A5; d_resp stays 0.
- i_read and d_read asserted on the same cycle from reset -> D served first (pmem_address=d_addr); after d_resp and one idle cycle, I served. Repeat with both held -> grants alternate I, D, I.
- d_write=1, d_wdata=0x1234..., addr 0x200; d_addr/d_wdata changed on the second SERVE cycle -> pmem_address stays 0x200 and wdata stays the original until pmem_resp; d_resp pulses once.
- d_read and d_write both high -> pmem_write=1, pmem_read=0.
- TIMEOUT=8, pmem_resp never asserted -> after 8 SERVE cycles: arb_err=1, strobes drop, i_resp pulses with i_rdata=0. arb_err remains 1 through later good transactions until rst.
- TIMEOUT=8, pmem_resp exactly on the 8th cycle -> normal completion, arb_err=0.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: I-cache, D-cache and physical-memory line ports seen by the arbiter
interface cache_mem_arbiter_if #(parameter int ADDR_W = 32, parameter int LINE_W = 256);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              arb_err;
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata, arb_err
  );
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata, arb_err
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory line port between I- and D-cache with D-first round-robin and a service watchdog
module cache_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 0
) (
  input logic clk,
  input logic rst,
  cache_mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic last_d, d_req, grant_d, grant_i, serving, timeout, done;
  assign d_req   = bus.d_read | bus.d_write;
  // on a tie the side that did not win last time gets the line
  assign grant_d = d_req && !(bus.i_read && last_d);
  assign grant_i = bus.i_read && !grant_d;
  assign serving = state == SERVE_I || state == SERVE_D;
  assign timeout = TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1) && !bus.pmem_resp;
  assign done    = serving && (bus.pmem_resp || timeout);
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = grant_d ? SERVE_D : grant_i ? SERVE_I : IDLE;
      SERVE_I: next = done ? RESP_I : SERVE_I;
      SERVE_D: next = done ? RESP_D : SERVE_D;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d           <= 1'b0;
      cnt              <= '0;
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= {ADDR_W{1'b0}};
      bus.pmem_wdata   <= {LINE_W{1'b0}};
      bus.i_rdata      <= {LINE_W{1'b0}};
      bus.d_rdata      <= {LINE_W{1'b0}};
      bus.i_resp       <= 1'b0;
      bus.d_resp       <= 1'b0;
      bus.arb_err      <= 1'b0;
    end else begin
      bus.i_resp <= next == RESP_I;
      bus.d_resp <= next == RESP_D;
      if (state == IDLE && (grant_d || grant_i)) begin
        last_d           <= grant_d;
        cnt              <= '0;
        bus.pmem_address <= grant_d ? bus.d_addr : bus.i_addr;
        bus.pmem_wdata   <= grant_d ? bus.d_wdata : {LINE_W{1'b0}};
        bus.pmem_write   <= grant_d && bus.d_write;
        bus.pmem_read    <= grant_i || !bus.d_write;
      end else if (serving) begin
        cnt <= cnt + 1'b1;
        if (done) begin
          bus.pmem_read  <= 1'b0;
          bus.pmem_write <= 1'b0;
          if (timeout) bus.arb_err <= 1'b1;
          if (state == SERVE_I) bus.i_rdata <= bus.pmem_resp ? bus.pmem_rdata : {LINE_W{1'b0}};
          else bus.d_rdata <= bus.pmem_resp ? bus.pmem_rdata : {LINE_W{1'b0}};
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed and randomized checks of cache_mem_arbiter against a transaction-level model
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  bit finished = 1'b0;
  cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) b ();
  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(string n, logic [LW-1:0] a, logic [LW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // model: one transaction at a time; phase 0 = idle, 1 = memory busy, 2 = response cycle
  int phase, age;
  bit who_d, m_last_d, m_rd, m_wr, m_ir, m_dr, m_err, dq;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, m_ird, m_drd, v;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase = 0; age = 0; who_d = 0; m_last_d = 0; m_rd = 0; m_wr = 0;
      m_ir = 0; m_dr = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
    end else begin
      m_ir = 0;
      m_dr = 0;
      if (phase == 0) begin
        dq = b.d_read | b.d_write;
        if (dq || b.i_read) begin
          who_d = dq && !(b.i_read && m_last_d);
          m_last_d = who_d;
          m_addr = who_d ? b.d_addr : b.i_addr;
          m_wdata = b.d_wdata;
          m_wr = who_d && b.d_write;
          m_rd = !m_wr;
          age = 0;
          phase = 1;
        end
      end else if (phase == 1) begin
        age++;
        if (b.pmem_resp || age == TO) begin
          v = b.pmem_resp ? b.pmem_rdata : '0;
          if (!b.pmem_resp) m_err = 1;
          if (who_d) begin m_drd = v; m_dr = 1; end
          else begin m_ird = v; m_ir = 1; end
          m_rd = 0;
          m_wr = 0;
          phase = 2;
        end
      end else phase = 0;
    end
  end
  always @(negedge clk) begin
    if (!rst && !finished) begin
      chk("m_pmem_read", LW'(b.pmem_read), LW'(m_rd));
      chk("m_pmem_write", LW'(b.pmem_write), LW'(m_wr));
      chk("m_i_resp", LW'(b.i_resp), LW'(m_ir));
      chk("m_d_resp", LW'(b.d_resp), LW'(m_dr));
      chk("m_arb_err", LW'(b.arb_err), LW'(m_err));
      if (phase == 1) chk("m_pmem_address", LW'(b.pmem_address), LW'(m_addr));
      if (m_wr) chk("m_pmem_wdata", b.pmem_wdata, m_wdata);
      if (m_ir) chk("m_i_rdata", b.i_rdata, m_ird);
      if (m_dr) chk("m_d_rdata", b.d_rdata, m_drd);
    end
  end
  logic [LW-1:0] a5, w0, d7;
  initial begin
    a5 = {32{8'hA5}};
    w0 = {8{32'h12345678}};
    d7 = {32{8'hD7}};
    b.i_read = 0; b.i_addr = '0; b.d_read = 0; b.d_write = 0; b.d_addr = '0;
    b.d_wdata = '0; b.pmem_rdata = a5; b.pmem_resp = 0;
    #12 rst = 0;
    chk("reset_outputs", LW'({b.pmem_read, b.pmem_write, b.i_resp, b.d_resp, b.arb_err}), '0);
    chk("reset_address", LW'(b.pmem_address), '0);
    tick();
    b.d_write = 1; b.d_addr = 32'h180; b.d_wdata = w0;
    tick();
    chk("pre_reset_write", LW'(b.pmem_write), 1);
    rst = 1;
    #1;
    chk("async_reset_strobes", LW'({b.pmem_read, b.pmem_write, b.i_resp, b.d_resp}), '0);
    chk("async_reset_address", LW'(b.pmem_address), '0);
    chk("async_reset_wdata", b.pmem_wdata, '0);
    rst = 0;
    b.d_write = 0;
    b.d_read = 1; b.d_addr = 32'h100; b.i_read = 1; b.i_addr = 32'h80;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("tie_address", LW'(b.pmem_address), (g % 2 == 0) ? LW'(32'h100) : LW'(32'h80));
      chk("tie_read", LW'(b.pmem_read), 1);
      b.pmem_resp = 1;
      tick();
      b.pmem_resp = 0;
      chk("tie_resp", LW'({b.i_resp, b.d_resp}), (g % 2 == 0) ? LW'(2'b01) : LW'(2'b10));
      tick();
    end
    b.d_read = 0; b.i_read = 0;
    b.i_addr = 32'h40;
    b.i_read = 1;
    tick();
    chk("i_only_read", LW'(b.pmem_read), 1);
    chk("i_only_address", LW'(b.pmem_address), LW'(32'h40));
    repeat (4) tick();
    b.pmem_resp = 1; b.pmem_rdata = a5;
    tick();
    b.pmem_resp = 0; b.i_read = 0;
    chk("i_only_resp", LW'({b.i_resp, b.d_resp, b.pmem_read}), LW'(3'b100));
    chk("i_only_rdata", b.i_rdata, a5);
    tick();
    chk("i_only_pulse_end", LW'(b.i_resp), 0);
    b.d_write = 1; b.d_addr = 32'h200; b.d_wdata = w0;
    tick();
    chk("wb_strobes", LW'({b.pmem_write, b.pmem_read}), LW'(2'b10));
    tick();
    b.d_addr = 32'h300; b.d_wdata = ~w0;
    tick();
    chk("wb_hold_address", LW'(b.pmem_address), LW'(32'h200));
    chk("wb_hold_wdata", b.pmem_wdata, w0);
    b.pmem_resp = 1;
    tick();
    b.pmem_resp = 0; b.d_write = 0;
    chk("wb_resp", LW'(b.d_resp), 1);
    tick();
    chk("wb_pulse_end", LW'(b.d_resp), 0);
    b.d_read = 1; b.d_write = 1; b.d_addr = 32'h240;
    tick();
    chk("rw_both_strobes", LW'({b.pmem_write, b.pmem_read}), LW'(2'b10));
    b.pmem_resp = 1;
    tick();
    b.pmem_resp = 0; b.d_read = 0; b.d_write = 0;
    tick();
    b.i_read = 1; b.i_addr = 32'h60;
    tick();
    repeat (7) tick();
    chk("edge_err_before", LW'({b.arb_err, b.pmem_read}), LW'(2'b01));
    b.pmem_resp = 1; b.pmem_rdata = d7;
    tick();
    b.pmem_resp = 0; b.i_read = 0;
    chk("edge_resp", LW'({b.i_resp, b.arb_err}), LW'(2'b10));
    chk("edge_rdata", b.i_rdata, d7);
    tick();
    b.i_read = 1; b.i_addr = 32'h70;
    tick();
    repeat (7) tick();
    chk("wd_cycle8", LW'({b.arb_err, b.pmem_read}), LW'(2'b01));
    tick();
    b.i_read = 0;
    chk("wd_abort", LW'({b.arb_err, b.pmem_read, b.i_resp}), LW'(3'b101));
    chk("wd_rdata_zero", b.i_rdata, '0);
    tick();
    chk("wd_pulse_end", LW'(b.i_resp), 0);
    b.d_read = 1; b.d_addr = 32'h280;
    tick();
    b.pmem_resp = 1;
    tick();
    b.pmem_resp = 0; b.d_read = 0;
    chk("wd_sticky", LW'({b.d_resp, b.arb_err}), LW'(2'b11));
    tick();
    rst = 1;
    #1;
    chk("wd_cleared", LW'(b.arb_err), 0);
    rst = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 599) == 0) begin
        rst = 1;
        #1 rst = 0;
      end
      if (b.i_resp || (b.i_read && $urandom_range(0, 63) == 0)) b.i_read = 0;
      else if (!b.i_read && $urandom_range(0, 3) == 0) begin
        b.i_read = 1;
        b.i_addr = $urandom;
      end else if ($urandom_range(0, 15) == 0) b.i_addr = $urandom;
      if (b.d_resp || ((b.d_read || b.d_write) && $urandom_range(0, 63) == 0)) begin
        b.d_read = 0;
        b.d_write = 0;
      end else if (!(b.d_read || b.d_write) && $urandom_range(0, 3) == 0) begin
        b.d_read = $urandom_range(0, 2) != 1;
        b.d_write = $urandom_range(0, 2) != 0 || !b.d_read;
        b.d_addr = $urandom;
        b.d_wdata = rnd_line();
      end else if ($urandom_range(0, 15) == 0) begin
        b.d_addr = $urandom;
        b.d_wdata = rnd_line();
      end
      b.pmem_resp = (b.pmem_read || b.pmem_write) ? $urandom_range(0, 4) == 0 : $urandom_range(0, 15) == 0;
      b.pmem_rdata = rnd_line();
    end
    finished = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
